// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and state encoding for the 1x4 demux scheduler
package demux_sched_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_DIR = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} st_t;
endpackage

// File: rtl/demux_sched_1x4_rr_pick4.sv
// rr_pick4: first enabled channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] en_mask,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  pick,
  output logic              pick_ok
);
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    dbl = {en_mask, en_mask} >> ptr;
    rot = dbl[NUM_CH-1:0];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick = ptr + off;
    pick_ok = |en_mask;
  end
endmodule

// File: rtl/demux_sched_1x4.sv
// demux_sched_1x4: round-robin/directed 1-to-4 word scheduler; DEMUX_SCHED_COUNT_EN adds per-channel fire counters cnt0..cnt3
module demux_sched_1x4
  import demux_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_dest,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic [NUM_CH-1:0] out_ready
`ifdef DEMUX_SCHED_COUNT_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2,
  output logic [15:0]       cnt3
`endif
);
  st_t st, st_nx;
  logic [SEL_W-1:0] ptr, pick;
  logic rr_ok, pick_ok, dir, fire, in_fire;
  rr_pick4 u_pick (
    .en_mask(en_mask),
    .ptr    (ptr),
    .pick   (pick),
    .pick_ok(rr_ok)
  );
  always_comb begin
    dir = mode == MODE_DIR;
    fire = (st == ST_HOLD) && out_ready[sel];
    pick_ok = dir ? en_mask[in_dest] : rr_ok;
    in_ready = !rst && ((st == ST_IDLE) || fire) && pick_ok;
    in_fire = in_valid && in_ready;
    st_nx = in_fire ? ST_HOLD : fire ? ST_IDLE : st;
    out_valid = (st == ST_HOLD) ? NUM_CH'(1) << sel : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      ptr <= '0;
      sel <= '0;
      out_data <= '0;
    end else begin
      st <= st_nx;
      if (in_fire) begin
        out_data <= in_data;
        sel <= dir ? in_dest : pick;
        if (!dir) ptr <= pick + 2'd1;
      end
    end
  end
`ifdef DEMUX_SCHED_COUNT_EN
  logic [15:0] cnt [NUM_CH];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    else if (fire) cnt[sel] <= cnt[sel] + 16'd1;
  end
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif
endmodule
